// File: rtl/ccg_truth_table_sweeper.sv
// ccg_truth_table_sweeper
// Walks a combinational netlist through every input vector. Each vector is
// held for SETTLE cycles and the outputs are then sampled. The sampled row is
// streamed out over valid/ready and folded into a MISR signature, while
// per-output constant-one / constant-zero flags are tracked.
module ccg_truth_table_sweeper #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 20,
    parameter int SETTLE = 1,
    parameter logic [N_OUT-1:0] POLY = N_OUT'(20'h00009)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [N_IN-1:0]  x_o,
    input  logic [N_OUT-1:0] y_i,
    output logic             row_valid,
    input  logic             row_ready,
    output logic [N_IN-1:0]  row_idx,
    output logic [N_OUT-1:0] row_data,
    output logic [N_OUT-1:0] signature,
    output logic [N_OUT-1:0] const_one,
    output logic [N_OUT-1:0] const_zero
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_APPLY   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_EMIT    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam int              CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  IDX_LAST = {N_IN{1'b1}};

    // Reject parameter values the design cannot support.
    generate
        if (SETTLE < 1 || N_IN < 1 || N_IN > 12 || N_OUT < 2 || N_OUT > 32) begin : g_bad_param
            $error("ccg_truth_table_sweeper: illegal parameter value");
        end
    endgenerate

    logic [2:0]       state_q, state_d;
    logic [N_IN-1:0]  idx_q, idx_d;
    logic [N_IN-1:0]  x_q, x_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0]  row_idx_q, row_idx_d;
    logic [N_OUT-1:0] row_data_q, row_data_d;
    logic [N_OUT-1:0] sig_q, sig_d;
    logic [N_OUT-1:0] c1_q, c1_d;
    logic [N_OUT-1:0] c0_q, c0_d;

    // Next-state logic for the sweep controller and its datapath.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        row_idx_d  = row_idx_q;
        row_data_d = row_data_q;
        sig_d      = sig_q;
        c1_d       = c1_q;
        c0_d       = c0_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    sig_d   = '0;
                    c1_d    = '1;
                    c0_d    = '1;
                    cnt_d   = CNT_INIT;
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                if (cnt_q == '0) state_d = S_CAPTURE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_CAPTURE: begin
                row_data_d = y_i;
                row_idx_d  = idx_q;
                sig_d      = ({sig_q[N_OUT-2:0], 1'b0} ^ (sig_q[N_OUT-1] ? POLY : '0)) ^ y_i;
                c1_d       = c1_q & y_i;
                c0_d       = c0_q & ~y_i;
                state_d    = S_EMIT;
            end
            S_EMIT: begin
                if (row_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = CNT_INIT;
                        state_d = S_APPLY;
                    end
                end
            end
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // x_o follows idx while a sweep is active but keeps the last vector
        // once the controller drops back to IDLE (idx itself wraps to 0).
        x_d = (state_d != S_IDLE) ? idx_d : x_q;
    end

    // State registers; synchronous reset has priority and aborts any sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            x_q        <= '0;
            cnt_q      <= '0;
            row_idx_q  <= '0;
            row_data_q <= '0;
            sig_q      <= '0;
            c1_q       <= '0;
            c0_q       <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            x_q        <= x_d;
            cnt_q      <= cnt_d;
            row_idx_q  <= row_idx_d;
            row_data_q <= row_data_d;
            sig_q      <= sig_d;
            c1_q       <= c1_d;
            c0_q       <= c0_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign row_valid  = (state_q == S_EMIT);
    assign x_o        = x_q;
    assign row_idx    = row_idx_q;
    assign row_data   = row_data_q;
    assign signature  = sig_q;
    assign const_one  = c1_q;
    assign const_zero = c0_q;

endmodule

// File: tb/tb_ccg_truth_table_sweeper.sv
// Scoreboard bench for ccg_truth_table_sweeper: stimulus queues expected rows,
// negedge monitors compare every presented row and the end-of-sweep results.
module tb_ccg_truth_table_sweeper;

    typedef struct {
        logic [3:0]  idx;
        logic [19:0] data;
    } row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic ready_a = 1'b1, ready_b = 1'b1;
    logic tog = 1'b0;
    int   y_mode = 0;

    logic [19:0] y_a, y_b = '0, y_b_nxt = '0;
    logic        busy_a, done_a, valid_a, busy_b, done_b, valid_b;
    logic [3:0]  x_a, ridx_a, x_b, ridx_b;
    logic [19:0] rdata_a, sig_a, c1_a, c0_a, rdata_b, sig_b, c1_b, c0_b;

    int errs = 0, checks = 0;
    row_t qa[$], qb[$];
    row_t dummy;
    logic [19:0] exp_sig_a, exp_c1_a, exp_c0_a, exp_sig_b, exp_c1_b, exp_c0_b;
    int exp_done_a = 0, exp_done_b = 0;
    int cyc_a = 0, cyc_b = 0, ndone_a = 0, ndone_b = 0;
    logic bprev_a = 1'b0, bprev_b = 1'b0, seen_a = 1'b0, seen_b = 1'b0;

    always #5 clk = ~clk;

    ccg_truth_table_sweeper dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .x_o(x_a), .y_i(y_a), .row_valid(valid_a), .row_ready(ready_a),
        .row_idx(ridx_a), .row_data(rdata_a), .signature(sig_a),
        .const_one(c1_a), .const_zero(c0_a)
    );

    ccg_truth_table_sweeper #(.SETTLE(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .x_o(x_b), .y_i(y_b), .row_valid(valid_b), .row_ready(ready_b),
        .row_idx(ridx_b), .row_data(rdata_b), .signature(sig_b),
        .const_one(c1_b), .const_zero(c0_b)
    );

    // Netlist model for dut_a.
    always_comb begin
        y_a = '0;
        case (y_mode)
            1: y_a = (x_a == 4'd0) ? 20'h00001 : 20'h00000;
            2: y_a = {16'h0000, x_a};
            default: y_a = '0;
        endcase
    end

    // dut_b netlist responds one cycle late to a new vector.
    initial forever begin
        @(posedge clk); #1;
        y_b = y_b_nxt;
        y_b_nxt = {16'h0000, x_b};
    end

    // Consumer for dut_a: either always ready or toggling every cycle.
    initial forever begin
        @(posedge clk); #1;
        if (tog) ready_a = ~ready_a;
        else     ready_a = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor for dut_a.
    always @(negedge clk) begin
        if (busy_a && !bprev_a) cyc_a = 1;
        else cyc_a++;
        bprev_a = busy_a;
        if (valid_a) begin
            if (qa.size() == 0) chk("a_extra_row", 32'd1, 32'd0);
            else begin
                chk("a_row_idx", {28'd0, ridx_a}, {28'd0, qa[0].idx});
                chk("a_row_data", {12'd0, rdata_a}, {12'd0, qa[0].data});
                if (ready_a) dummy = qa.pop_front();
            end
        end
        if (done_a) begin
            ndone_a++;
            seen_a = 1'b1;
            if (exp_done_a != 0) chk("a_done_cycle", cyc_a, exp_done_a);
            chk("a_signature", {12'd0, sig_a}, {12'd0, exp_sig_a});
            chk("a_const_one", {12'd0, c1_a}, {12'd0, exp_c1_a});
            chk("a_const_zero", {12'd0, c0_a}, {12'd0, exp_c0_a});
        end
    end

    // Monitor for dut_b.
    always @(negedge clk) begin
        if (busy_b && !bprev_b) cyc_b = 1;
        else cyc_b++;
        bprev_b = busy_b;
        if (valid_b) begin
            if (qb.size() == 0) chk("b_extra_row", 32'd1, 32'd0);
            else begin
                chk("b_row_idx", {28'd0, ridx_b}, {28'd0, qb[0].idx});
                chk("b_row_data", {12'd0, rdata_b}, {12'd0, qb[0].data});
                if (ready_b) dummy = qb.pop_front();
            end
        end
        if (done_b) begin
            ndone_b++;
            seen_b = 1'b1;
            chk("b_done_cycle", cyc_b, exp_done_b);
            chk("b_signature", {12'd0, sig_b}, {12'd0, exp_sig_b});
            chk("b_const_one", {12'd0, c1_b}, {12'd0, exp_c1_b});
            chk("b_const_zero", {12'd0, c0_b}, {12'd0, exp_c0_b});
        end
    end

    task automatic push_a(input int mode, input int n);
        row_t r;
        for (int k = 0; k < n; k++) begin
            r.idx  = 4'(k);
            r.data = (mode == 1) ? ((k == 0) ? 20'h00001 : 20'h0) :
                     (mode == 2) ? 20'(k) : 20'h0;
            qa.push_back(r);
        end
    endtask

    // Leaves the caller #1 into cycle 1 (start accepted at edge 0).
    task automatic go_a();
        seen_a = 1'b0;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    task automatic wait_a(input int lim);
        int n = 0;
        while (!seen_a && n < lim) begin @(posedge clk); n++; end
        if (!seen_a) chk("a_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy_a}, 0);
        chk("rst_done", {31'd0, done_a}, 0);
        chk("rst_valid", {31'd0, valid_a}, 0);
        chk("rst_x", {28'd0, x_a}, 0);
        chk("rst_row_idx", {28'd0, ridx_a}, 0);
        chk("rst_row_data", {12'd0, rdata_a}, 0);
        chk("rst_sig", {12'd0, sig_a}, 0);
        chk("rst_c1", {12'd0, c1_a}, 0);
        chk("rst_c0", {12'd0, c0_a}, 0);
        rst = 1'b0;

        // Sweep 1: outputs tied low
        y_mode = 0; exp_done_a = 49;
        exp_sig_a = 20'h00000; exp_c0_a = 20'hFFFFF; exp_c1_a = 20'h0;
        push_a(0, 16); go_a(); wait_a(200);
        chk("a_x_after_sweep", {28'd0, x_a}, 32'd15);

        // Sweep 2: single one-hot row
        y_mode = 1;
        exp_sig_a = 20'h08000; exp_c0_a = 20'hFFFFE; exp_c1_a = 20'h0;
        push_a(1, 16); go_a(); wait_a(200);

        // Sweep 3: identity on low nibble, consumer toggling ready
        y_mode = 2; tog = 1'b1; exp_done_a = 0;
        exp_sig_a = 20'h008F7; exp_c0_a = 20'hFFFF0; exp_c1_a = 20'h0;
        push_a(2, 16); go_a(); wait_a(400);
        tog = 1'b0;
        @(posedge clk); #1;

        // Sweep 4: stray start pulses at cycles 10 and 30 are ignored
        exp_done_a = 49;
        push_a(2, 16); go_a();
        repeat (9) @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (19) @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        wait_a(200);

        // Sweep 5: reset during cycle 20 aborts after rows 0..5
        push_a(2, 6); go_a();
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_busy", {31'd0, busy_a}, 0);
        chk("abort_valid", {31'd0, valid_a}, 0);
        chk("abort_sig", {12'd0, sig_a}, 0);
        chk("abort_x", {28'd0, x_a}, 0);
        chk("abort_done", {31'd0, done_a}, 0);
        chk("abort_rows_left", qa.size(), 0);
        repeat (5) @(posedge clk);
        #1 chk("abort_no_done", ndone_a, 4);

        // Sweep 6: fresh sweep after abort
        push_a(2, 16); go_a(); wait_a(200);

        // dut_b: SETTLE=3 with a late-responding netlist
        exp_done_b = 81;
        exp_sig_b = 20'h008F7; exp_c0_b = 20'hFFFF0; exp_c1_b = 20'h0;
        for (int k = 0; k < 16; k++) begin
            row_t r;
            r.idx = 4'(k); r.data = 20'(k);
            qb.push_back(r);
        end
        seen_b = 1'b0;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        for (int n = 0; n < 300 && !seen_b; n++) @(posedge clk);
        if (!seen_b) chk("b_timeout", 32'd0, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("a_done_count", ndone_a, 5);
        chk("b_done_count", ndone_b, 1);
        chk("a_rows_left", qa.size(), 0);
        chk("b_rows_left", qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        errs++;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $fatal(1, "watchdog");
    end

endmodule
